// File: rtl/mc_controller.sv
// ============================================================================
// mc_controller -- multi-cycle FETCH/DECODE/EXE/MEM/WB sequencer for the
//                  MIPS-subset datapath with a variable-latency memory port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mc_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_is_data,
  output logic             dm_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [2:0]       npc_op,
  output logic [2:0]       alu_op,
  output logic [2:0]       ext_op,
  output logic [2:0]       ab_sel,
  output logic [2:0]       rw_sel,
  output logic             grf_we,
  output logic [4:0]       grf_addr,
  output logic [2:0]       state,
  output logic             retired,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] FETCH  = 3'b000;
  localparam logic [2:0] DECODE = 3'b001;
  localparam logic [2:0] EXE    = 3'b010;
  localparam logic [2:0] MEM    = 3'b011;
  localparam logic [2:0] WB     = 3'b100;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;

  logic [5:0] opcode, funct;
  logic       is_add, is_sub, is_jr, is_ori, is_lw, is_sw, is_beq, is_lui, is_jal;
  logic       is_valid;
  logic [2:0] dec_alu, dec_ext, dec_ab, dec_rw;
  logic [4:0] dec_dst;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  assign is_add = (opcode == OP_RTYPE) && (funct == FN_ADD);
  assign is_sub = (opcode == OP_RTYPE) && (funct == FN_SUB);
  assign is_jr  = (opcode == OP_RTYPE) && (funct == FN_JR);
  assign is_ori = (opcode == OP_ORI);
  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);
  assign is_beq = (opcode == OP_BEQ);
  assign is_lui = (opcode == OP_LUI);
  assign is_jal = (opcode == OP_JAL);

  // An all-zero word is a nop even though it shares the R-type opcode.
  assign is_valid = (|instr) && (is_add || is_sub || is_jr || is_ori || is_lw ||
                                 is_sw || is_beq || is_lui || is_jal);

  // Per-instruction selects, held constant from EXE through WB.
  always_comb begin
    dec_alu = 3'b000;
    dec_ext = 3'b000;
    dec_ab  = 3'b000;
    dec_rw  = 3'b000;
    dec_dst = 5'd0;
    if (is_sub || is_beq) dec_alu = 3'b001;
    if (is_ori)           dec_alu = 3'b011;
    if (is_ori)           dec_ext = 3'b001;
    if (is_lui)           dec_ext = 3'b010;
    if (is_ori || is_lw || is_sw || is_lui) dec_ab = 3'b001;
    if (is_lui)           dec_rw  = 3'b001;
    if (is_lw)            dec_rw  = 3'b010;
    if (is_jal)           dec_rw  = 3'b011;
    if (is_add || is_sub)                dec_dst = instr[15:11];
    if (is_lw || is_lui || is_ori)       dec_dst = instr[20:16];
    if (is_jal)                          dec_dst = 5'd31;
  end

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_is_data = 1'b0;
    dm_we       = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    npc_op      = 3'b000;
    alu_op      = 3'b000;
    ext_op      = 3'b000;
    ab_sel      = 3'b000;
    rw_sel      = 3'b000;
    grf_we      = 1'b0;
    grf_addr    = 5'd0;
    retired     = 1'b0;

    if (state_q == EXE || state_q == MEM || state_q == WB) begin
      alu_op   = dec_alu;
      ext_op   = dec_ext;
      ab_sel   = dec_ab;
      rw_sel   = dec_rw;
      grf_addr = dec_dst;
    end

    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (!is_valid) begin
          retired = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = EXE;
        end
      end
      EXE: begin
        if (is_beq) begin
          npc_op  = 3'b001;
          pc_we   = zero;
          retired = 1'b1;
          state_d = FETCH;
        end else if (is_jal) begin
          npc_op  = 3'b010;
          pc_we   = 1'b1;
          grf_we  = 1'b1;
          retired = 1'b1;
          state_d = FETCH;
        end else if (is_jr) begin
          npc_op  = 3'b011;
          pc_we   = 1'b1;
          retired = 1'b1;
          state_d = FETCH;
        end else if (is_lw || is_sw) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        mem_req     = 1'b1;
        mem_is_data = 1'b1;
        dm_we       = is_sw;
        if (mem_ready) begin
          if (is_lw) begin
            state_d = WB;
          end else begin
            retired = 1'b1;
            state_d = FETCH;
          end
        end
      end
      WB: begin
        grf_we  = 1'b1;
        retired = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Reset suppresses every side effect in the same cycle, abandoning any access.
    if (reset) begin
      mem_req     = 1'b0;
      mem_is_data = 1'b0;
      dm_we       = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      npc_op      = 3'b000;
      alu_op      = 3'b000;
      ext_op      = 3'b000;
      ab_sel      = 3'b000;
      rw_sel      = 3'b000;
      grf_we      = 1'b0;
      grf_addr    = 5'd0;
      retired     = 1'b0;
    end
  end

  assign instr_count_d = instr_count_q + CNT_W'(retired);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign state       = state_q;
  assign instr_count = instr_count_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_controller.sv
// ============================================================================
// tb_mc_controller -- trace-based checker for mc_controller: each instruction
//                     is expanded into its expected per-cycle output trace.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mc_controller;

  localparam int CW = 4;

  logic          clk;
  logic          reset;
  logic [31:0]   instr;
  logic          zero;
  logic          mem_ready;
  logic          mem_req, mem_is_data, dm_we, ir_we, pc_we, grf_we, retired;
  logic [2:0]    npc_op, alu_op, ext_op, ab_sel, rw_sel, state;
  logic [4:0]    grf_addr;
  logic [CW-1:0] instr_count;

  mc_controller #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_is_data(mem_is_data), .dm_we(dm_we), .ir_we(ir_we),
    .pc_we(pc_we), .npc_op(npc_op), .alu_op(alu_op), .ext_op(ext_op),
    .ab_sel(ab_sel), .rw_sel(rw_sel), .grf_we(grf_we), .grf_addr(grf_addr),
    .state(state), .retired(retired), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rdy, zr;
    logic [31:0] ir;
    logic [2:0]  st;
    logic        req, isd, dwe, irwe, pcwe, gwe, ret;
    logic [2:0]  npc, alu, ext, ab, rw;
    logic [4:0]  ga;
    logic [3:0]  cnt;
  } rec_t;

  typedef enum int {K_ADD, K_SUB, K_JR, K_ORI, K_LW, K_SW, K_BEQ, K_LUI, K_JAL, K_BAD} kind_t;

  rec_t        tq[$];
  rec_t        cur;
  bit          cur_valid = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_ir = 32'd0;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic kind_t classify(input logic [31:0] w);
    logic [5:0] op, fn;
    op = w[31:26];
    fn = w[5:0];
    if (w == 32'd0) return K_BAD;
    case (op)
      6'h00:   return (fn == 6'h20) ? K_ADD : (fn == 6'h22) ? K_SUB : (fn == 6'h08) ? K_JR : K_BAD;
      6'h0D:   return K_ORI;
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      6'h04:   return K_BEQ;
      6'h0F:   return K_LUI;
      6'h03:   return K_JAL;
      default: return K_BAD;
    endcase
  endfunction

  function automatic rec_t blank(input logic [2:0] st);
    rec_t r;
    r = '{rst: 1'b0, rdy: 1'($urandom_range(0, 1)), zr: 1'($urandom_range(0, 1)),
          ir: m_ir, st: st, req: 1'b0, isd: 1'b0, dwe: 1'b0, irwe: 1'b0, pcwe: 1'b0,
          gwe: 1'b0, ret: 1'b0, npc: 3'b000, alu: 3'b000, ext: 3'b000, ab: 3'b000,
          rw: 3'b000, ga: 5'd0, cnt: 4'(m_cnt)};
    return r;
  endfunction

  // Instruction-level meaning of the selects, shared by all post-decode cycles.
  function automatic rec_t with_sel(input rec_t r0, input kind_t k, input logic [31:0] w);
    rec_t r;
    r = r0;
    r.alu = (k == K_SUB || k == K_BEQ) ? 3'b001 : (k == K_ORI) ? 3'b011 : 3'b000;
    r.ext = (k == K_ORI) ? 3'b001 : (k == K_LUI) ? 3'b010 : 3'b000;
    r.ab  = (k == K_ORI || k == K_LW || k == K_SW || k == K_LUI) ? 3'b001 : 3'b000;
    r.rw  = (k == K_LUI) ? 3'b001 : (k == K_LW) ? 3'b010 : (k == K_JAL) ? 3'b011 : 3'b000;
    r.ga  = (k == K_ADD || k == K_SUB) ? w[15:11] :
            (k == K_LW || k == K_LUI || k == K_ORI) ? w[20:16] :
            (k == K_JAL) ? 5'd31 : 5'd0;
    return r;
  endfunction

  function automatic void push(input rec_t r);
    tq.push_back(r);
    if (r.ret) m_cnt = (m_cnt + 1) % 16;
  endfunction

  function automatic void build(input logic [31:0] w, input logic zr, input int fw,
                                input int mw, input bit abort);
    kind_t k;
    rec_t  r;
    k = classify(w);
    for (int i = 0; i < fw; i++) begin
      r = blank(3'd0); r.rdy = 1'b0; r.req = 1'b1; push(r);
    end
    r = blank(3'd0); r.rdy = 1'b1; r.req = 1'b1; r.irwe = 1'b1; r.pcwe = 1'b1; push(r);
    m_ir = w;
    r = blank(3'd1);
    if (k == K_BAD) begin r.ret = 1'b1; push(r); return; end
    push(r);
    r = with_sel(blank(3'd2), k, w);
    r.zr = zr;
    if (k == K_BEQ) begin r.npc = 3'b001; r.pcwe = zr; r.ret = 1'b1; push(r); return; end
    if (k == K_JAL) begin r.npc = 3'b010; r.pcwe = 1'b1; r.gwe = 1'b1; r.ret = 1'b1; push(r); return; end
    if (k == K_JR)  begin r.npc = 3'b011; r.pcwe = 1'b1; r.ret = 1'b1; push(r); return; end
    push(r);
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i < mw; i++) begin
        r = with_sel(blank(3'd3), k, w);
        r.rdy = 1'b0; r.req = 1'b1; r.isd = 1'b1; r.dwe = (k == K_SW); push(r);
      end
      if (abort) begin
        r = blank(3'd3); r.rst = 1'b1; r.rdy = 1'b1; push(r);
        m_cnt = 0;
        return;
      end
      r = with_sel(blank(3'd3), k, w);
      r.rdy = 1'b1; r.req = 1'b1; r.isd = 1'b1; r.dwe = (k == K_SW);
      r.ret = (k == K_SW);
      push(r);
      if (k == K_SW) return;
    end
    r = with_sel(blank(3'd4), k, w);
    r.gwe = 1'b1; r.ret = 1'b1; push(r);
  endfunction

  task automatic chk(input string n, input int act, input int exp);
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, want %0d", n, $time, act, exp);
    end
  endtask

  task automatic lit(input string n, input int act, input int exp);
    n_vec++;
    chk(n, act, exp);
  endtask

  always @(negedge clk) begin
    if (cur_valid) begin
      n_vec++;
      chk("state",       int'(state),       int'(cur.st));
      chk("mem_req",     int'(mem_req),     int'(cur.req));
      chk("mem_is_data", int'(mem_is_data), int'(cur.isd));
      chk("dm_we",       int'(dm_we),       int'(cur.dwe));
      chk("ir_we",       int'(ir_we),       int'(cur.irwe));
      chk("pc_we",       int'(pc_we),       int'(cur.pcwe));
      chk("npc_op",      int'(npc_op),      int'(cur.npc));
      chk("alu_op",      int'(alu_op),      int'(cur.alu));
      chk("ext_op",      int'(ext_op),      int'(cur.ext));
      chk("ab_sel",      int'(ab_sel),      int'(cur.ab));
      chk("rw_sel",      int'(rw_sel),      int'(cur.rw));
      chk("grf_we",      int'(grf_we),      int'(cur.gwe));
      chk("grf_addr",    int'(grf_addr),    int'(cur.ga));
      chk("retired",     int'(retired),     int'(cur.ret));
      chk("instr_count", int'(instr_count), int'(cur.cnt));
    end
  end

  task automatic run_trace();
    rec_t r;
    while (tq.size() > 0) begin
      r = tq.pop_front();
      reset = r.rst; mem_ready = r.rdy; zero = r.zr; instr = r.ir;
      cur = r; cur_valid = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    cur_valid = 1'b0;
  endtask

  task automatic do_instr(input string n, input logic [31:0] w, input logic zr,
                          input int fw, input int mw, input int exp_len);
    build(w, zr, fw, mw, 1'b0);
    if (exp_len > 0) lit({n, "_cycles"}, tq.size(), exp_len);
    run_trace();
  endtask

  initial begin
    rec_t r;
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; instr = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    r = blank(3'd0); r.rst = 1'b1; r.rdy = 1'b1; push(r);
    run_trace();

    do_instr("add",    32'h0022_1820, 1'b0, 0, 0, 4);
    lit("count_after_add", int'(instr_count), 1);
    do_instr("lw",     32'h8C05_0004, 1'b0, 0, 2, 7);
    do_instr("beq_t",  32'h1022_0003, 1'b1, 0, 0, 3);
    do_instr("beq_nt", 32'h1022_0003, 1'b0, 0, 0, 3);
    do_instr("jal",    32'h0C00_0010, 1'b0, 0, 0, 3);
    do_instr("jr",     32'h03E0_0008, 1'b0, 0, 0, 3);
    do_instr("sub",    32'h0043_0822, 1'b0, 2, 0, 6);
    do_instr("ori",    32'h3424_00FF, 1'b0, 0, 0, 4);
    do_instr("lui",    32'h3C06_1234, 1'b0, 0, 0, 4);
    do_instr("sw",     32'hAC05_0008, 1'b0, 1, 1, 6);
    lit("count_after_10", int'(instr_count), 10);

    build(32'hAC05_0008, 1'b0, 0, 1, 1'b1);
    run_trace();
    lit("abort_state", int'(state), 0);
    lit("abort_count", int'(instr_count), 0);

    do_instr("nop",     32'h0000_0000, 1'b0, 0, 0, 2);
    do_instr("bad_op",  32'hFC00_0000, 1'b0, 0, 0, 2);
    do_instr("bad_fn",  32'h0022_183F, 1'b0, 0, 0, 2);
    for (int i = 0; i < 12; i++) do_instr("nop", 32'h0000_0000, 1'b0, 0, 0, 0);
    lit("count_15", int'(instr_count), 15);
    do_instr("nop_wrap", 32'h0000_0000, 1'b0, 0, 0, 2);
    lit("count_wrap", int'(instr_count), 0);
    do_instr("add_after_wrap", 32'h0022_1820, 1'b0, 1, 0, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
